// File: rtl/regfile_pkg.sv
// Shared types, default widths and address-bus helpers for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;

  // Upper bounds used by rd_field; the packed read-address bus is widened to MAX_BUS before slicing.
  localparam int unsigned MAX_ADDR_W = 16;
  localparam int unsigned MAX_RD     = 4;
  localparam int unsigned MAX_BUS    = MAX_RD * MAX_ADDR_W;

  // Returns port k's address (aw bits, zero-extended) from a packed address bus.
  function automatic logic [MAX_ADDR_W-1:0] rd_field(input logic [MAX_BUS-1:0] addr_bus,
                                                     input int unsigned        k,
                                                     input int unsigned        aw);
    logic [MAX_ADDR_W-1:0] mask;
    mask = (MAX_ADDR_W'(1) << aw) - MAX_ADDR_W'(1);
    return MAX_ADDR_W'(addr_bus >> (k * aw)) & mask;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One asynchronous read port: array value, with same-cycle write bypass and zero forcing.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] arr_data,
  input  logic              clearing,
  input  logic              wr_en0,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic              wr_en1,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [DATA_W-1:0] wr_data1,
  output logic [DATA_W-1:0] data
);

  // Priority: clear/zero-register forcing, then write port 1, then write port 0, then the array.
  always_comb begin
    data = arr_data;
    if (BYPASS && wr_en0 && (wr_addr0 == addr)) data = wr_data0;
    if (BYPASS && wr_en1 && (wr_addr1 == addr)) data = wr_data1;
    if (clearing || (ZERO_REG && (addr == '0))) data = '0;
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NUM_RD async read ports, two sync write ports, post-reset clear sequencer.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [1:0]               wr_en,
  input  logic [ADDR_W-1:0]        wr_addr0,
  input  logic [ADDR_W-1:0]        wr_addr1,
  input  logic [DATA_W-1:0]        wr_data0,
  input  logic [DATA_W-1:0]        wr_data1,
  output logic                     init_busy,
  output logic                     wr_drop,
  output logic                     wr_collide
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  rf_state_t         state, state_nx;
  logic [ADDR_W:0]   clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic clearing;
  logic clr_last;
  logic zero0, zero1;
  logic wr_ok0, wr_ok1;
  logic wr_hit;
  logic wr_do0;
  logic drop_nx;

  assign clearing = (state == CLEAR);
  assign clr_last = (clr_cnt == (ADDR_W+1)'(DEPTH - 1));

  // A write is "ok" when it will land in the array (or be bypassed); zero-register writes never are.
  assign zero0   = ZERO_REG && (wr_addr0 == '0);
  assign zero1   = ZERO_REG && (wr_addr1 == '0);
  assign wr_ok0  = !clearing && wr_en[0] && !zero0;
  assign wr_ok1  = !clearing && wr_en[1] && !zero1;
  assign wr_hit  = wr_ok0 && wr_ok1 && (wr_addr0 == wr_addr1);
  assign wr_do0  = wr_ok0 && !wr_hit;
  assign drop_nx = clearing ? (|wr_en) : ((wr_en[0] && zero0) || (wr_en[1] && zero1));

  // Next state: CLEAR walks the whole array once, then RUN until the next reset.
  always_comb begin
    state_nx = state;
    unique case (state)
      CLEAR:   if (clr_last) state_nx = RUN;
      RUN:     state_nx = RUN;
      default: state_nx = CLEAR;
    endcase
  end

  // State, clear counter and registered status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= CLEAR;
      clr_cnt    <= '0;
      init_busy  <= 1'b1;
      wr_drop    <= 1'b0;
      wr_collide <= 1'b0;
    end else begin
      state      <= state_nx;
      if (clearing) clr_cnt <= clr_cnt + (ADDR_W+1)'(1);
      init_busy  <= (state_nx == CLEAR);
      wr_drop    <= drop_nx;
      wr_collide <= wr_hit;
    end
  end

  // Array update: the sequencer owns the array during CLEAR; port 1 wins a same-address collision.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (clearing) begin
        mem[clr_cnt[ADDR_W-1:0]] <= '0;
      end else begin
        if (wr_do0) mem[wr_addr0] <= wr_data0;
        if (wr_ok1) mem[wr_addr1] <= wr_data1;
      end
    end
  end

  logic [MAX_BUS-1:0] rd_addr_ext;
  assign rd_addr_ext = MAX_BUS'(rd_addr);

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr_k;
    assign addr_k = ADDR_W'(rd_field(rd_addr_ext, k, ADDR_W));

    regfile_rd_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
    ) u_rd_port (
      .addr    (addr_k),
      .arr_data(mem[addr_k]),
      .clearing(clearing),
      .wr_en0  (wr_ok0),
      .wr_addr0(wr_addr0),
      .wr_data0(wr_data0),
      .wr_en1  (wr_ok1),
      .wr_addr1(wr_addr1),
      .wr_data1(wr_data1),
      .data    (rd_data[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: one bypassing and one non-bypassing instance share all inputs.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data_b, rd_data_n;
  logic [1:0]      wr_en;
  logic [AW-1:0]   wa0, wa1;
  logic [DW-1:0]   wd0, wd1;
  logic            busy_b, busy_n, drop_b, drop_n, col_b, col_n;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .wr_en(wr_en),
    .wr_addr0(wa0), .wr_addr1(wa1), .wr_data0(wd0), .wr_data1(wd1),
    .init_busy(busy_b), .wr_drop(drop_b), .wr_collide(col_b)
  );

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_n), .wr_en(wr_en),
    .wr_addr0(wa0), .wr_addr1(wa1), .wr_data0(wd0), .wr_data1(wd1),
    .init_busy(busy_n), .wr_drop(drop_n), .wr_collide(col_n)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Reference model: array contents, remaining clear writes and expected status pulses.
  logic [DW-1:0] mem_m [DEPTH];
  int            clr_left = 0;
  bit            busy_m = 1'b1, drop_m = 1'b0, col_m = 1'b0, known = 1'b0;

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
    if (clr_left > 0) return '0;
    if (a == '0) return '0;
    if (byp) begin
      if (wr_en[1] && wa1 == a) return wd1;
      if (wr_en[0] && wa0 == a) return wd0;
    end
    return mem_m[a];
  endfunction

  task automatic model_edge();
    bit z0, z1, v0, v1;
    if (!rst_n) begin
      known = 1'b1; clr_left = DEPTH; busy_m = 1'b1; drop_m = 1'b0; col_m = 1'b0;
    end else if (known) begin
      if (clr_left > 0) begin
        mem_m[DEPTH - clr_left] = '0;
        clr_left--;
        drop_m = |wr_en;
        col_m  = 1'b0;
        busy_m = (clr_left > 0);
      end else begin
        z0 = wr_en[0] && (wa0 == 0);
        z1 = wr_en[1] && (wa1 == 0);
        v0 = wr_en[0] && !z0;
        v1 = wr_en[1] && !z1;
        drop_m = z0 || z1;
        col_m  = v0 && v1 && (wa0 == wa1);
        if (v0) mem_m[wa0] = wd0;
        if (v1) mem_m[wa1] = wd1;
        busy_m = 1'b0;
      end
    end
  endtask

  // Check reads before the edge, advance one clock, then check the registered outputs.
  task automatic step(input bit chk_rd);
    logic [AW-1:0] a;
    #1;
    if (known && rst_n && chk_rd) begin
      for (int p = 0; p < NR; p++) begin
        a = rd_addr[p*AW +: AW];
        chk($sformatf("rd_byp p%0d a%0d", p, a), rd_data_b[p*DW +: DW], exp_rd(a, 1'b1));
        chk($sformatf("rd_nobyp p%0d a%0d", p, a), rd_data_n[p*DW +: DW], exp_rd(a, 1'b0));
      end
    end
    @(posedge clk);
    model_edge();
    #1;
    if (known) begin
      chk("init_busy_b", DW'(busy_b), DW'(busy_m));
      chk("init_busy_n", DW'(busy_n), DW'(busy_m));
      chk("wr_drop_b", DW'(drop_b), DW'(drop_m));
      chk("wr_drop_n", DW'(drop_n), DW'(drop_m));
      chk("wr_collide_b", DW'(col_b), DW'(col_m));
      chk("wr_collide_n", DW'(col_n), DW'(col_m));
    end
  endtask

  task automatic idle_inputs();
    wr_en = 2'b00; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
  endtask

  // Runs the post-reset clear, returning the number of edges init_busy stayed high.
  task automatic run_clear(output int n, output int drops);
    n = 0; drops = 0;
    for (int i = 0; i < 100; i++) begin
      idle_inputs();
      if (i == 5) begin
        wr_en = 2'b01; wa0 = 5'd2; wd0 = 32'h123;
      end
      rd_addr = {AW'($urandom_range(0, DEPTH-1)), AW'($urandom_range(0, DEPTH-1))};
      step(1'b1);
      n++;
      if (drop_b) drops++;
      if (!busy_b) break;
    end
  endtask

  typedef struct {
    logic [1:0]    en;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
    bit            ed;
    bit            ec;
  } vec_t;

  vec_t tbl [10];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n, drops;

    tbl[0] = '{2'b11, 5'd1, 32'd5,          5'd2, 32'd10, 5'd1, 5'd2, 32'd5,          32'd10,         1'b0, 1'b0};
    tbl[1] = '{2'b00, 5'd0, 32'd0,          5'd0, 32'd0,  5'd1, 5'd2, 32'd5,          32'd10,         1'b0, 1'b0};
    tbl[2] = '{2'b01, 5'd7, 32'hDEADBEEF,   5'd0, 32'd0,  5'd7, 5'd1, 32'hDEADBEEF,   32'd5,          1'b0, 1'b0};
    tbl[3] = '{2'b11, 5'd3, 32'h11,         5'd3, 32'h22, 5'd3, 5'd7, 32'h22,         32'hDEADBEEF,   1'b0, 1'b1};
    tbl[4] = '{2'b00, 5'd0, 32'd0,          5'd0, 32'd0,  5'd3, 5'd0, 32'h22,         32'd0,          1'b0, 1'b0};
    tbl[5] = '{2'b01, 5'd0, 32'h55,         5'd0, 32'd0,  5'd0, 5'd3, 32'd0,          32'h22,         1'b1, 1'b0};
    tbl[6] = '{2'b11, 5'd0, 32'd1,          5'd0, 32'd2,  5'd0, 5'd0, 32'd0,          32'd0,          1'b1, 1'b0};
    tbl[7] = '{2'b10, 5'd0, 32'd0,          5'd4, 32'd9,  5'd4, 5'd7, 32'd9,          32'hDEADBEEF,   1'b0, 1'b0};
    tbl[8] = '{2'b11, 5'd5, 32'hAA,         5'd0, 32'hBB, 5'd5, 5'd0, 32'hAA,         32'd0,          1'b1, 1'b0};
    tbl[9] = '{2'b00, 5'd0, 32'd0,          5'd0, 32'd0,  5'd5, 5'd4, 32'hAA,         32'd9,          1'b0, 1'b0};

    // Reset held two cycles, then the clear sequence with one write attempted mid-clear.
    rst_n = 1'b0; rd_addr = '0; idle_inputs();
    step(1'b0);
    step(1'b0);
    rst_n = 1'b1;
    run_clear(n, drops);
    chk("clear_len", DW'(n), DW'(DEPTH));
    chk("clear_drop_pulses", DW'(drops), DW'(1));

    // Every entry reads zero after the clear, entry 2 included.
    for (int i = 0; i < DEPTH; i++) begin
      idle_inputs();
      rd_addr = {AW'(DEPTH - 1 - i), AW'(i)};
      #1;
      chk($sformatf("cleared_b r%0d", i), rd_data_b[DW-1:0], '0);
      chk($sformatf("cleared_n r%0d", i), rd_data_n[DW-1:0], '0);
      step(1'b1);
    end

    // Directed vectors: same-cycle reads on the bypass instance and status pulses after the edge.
    for (int i = 0; i < 10; i++) begin
      wr_en = tbl[i].en; wa0 = tbl[i].a0; wd0 = tbl[i].d0; wa1 = tbl[i].a1; wd1 = tbl[i].d1;
      rd_addr = {tbl[i].ra1, tbl[i].ra0};
      #1;
      chk($sformatf("vec%0d rd0", i), rd_data_b[DW-1:0], tbl[i].e0);
      chk($sformatf("vec%0d rd1", i), rd_data_b[2*DW-1:DW], tbl[i].e1);
      step(1'b1);
      chk($sformatf("vec%0d drop", i), DW'(drop_b), DW'(tbl[i].ed));
      chk($sformatf("vec%0d collide", i), DW'(col_b), DW'(tbl[i].ec));
    end

    // Non-bypass instance: old value in the write cycle, new value the cycle after.
    wr_en = 2'b01; wa0 = 5'd7; wd0 = 32'h0BADF00D; wa1 = '0; wd1 = '0;
    rd_addr = {5'd0, 5'd7};
    #1;
    chk("nobyp_same_cycle", rd_data_n[DW-1:0], 32'hDEADBEEF);
    chk("byp_same_cycle", rd_data_b[DW-1:0], 32'h0BADF00D);
    step(1'b1);
    idle_inputs();
    #1;
    chk("nobyp_next_cycle", rd_data_n[DW-1:0], 32'h0BADF00D);
    step(1'b1);

    // Single-cycle reset mid-RUN: full clear again, r4 returns to zero.
    rst_n = 1'b0; idle_inputs();
    step(1'b0);
    rst_n = 1'b1;
    run_clear(n, drops);
    chk("reclear_len", DW'(n), DW'(DEPTH));
    idle_inputs();
    rd_addr = {5'd5, 5'd4};
    #1;
    chk("r4_after_reset", rd_data_b[DW-1:0], '0);
    chk("r5_after_reset", rd_data_b[2*DW-1:DW], '0);
    step(1'b1);

    // Randomized traffic against the model, biased toward low addresses for collisions and r0.
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      wr_en = 2'($urandom_range(0, 3));
      wa0 = AW'($urandom_range(0, 7));
      wa1 = AW'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) wa1 = AW'($urandom_range(0, DEPTH-1));
      wd0 = $urandom;
      wd1 = $urandom;
      rd_addr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      if ($urandom_range(0, 1) == 0) rd_addr[AW-1:0] = wa0;
      step(1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
